fetch_unit: RTL

Parametrised instruction-fetch front end for the MIPS core. It replaces the bare pc register plus the fixed +4 adder.
- Owns the fetch PC and drives a synchronous instruction memory.
- Buffers fetched words with their PCs in a small FIFO.
- Hands instructions to instruction decode over a valid/ready handshake.
- Accepts redirects (branch, jump, jr) from downstream, which flush all wrong-path work.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Used by fetch_unit and fetch_fifo.
package fetch_pkg;

  localparam int INSTR_BYTES   = 4;
  localparam int PC_ALIGN_BITS = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
// Flush has priority over push; pointers carry a wrap bit.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  entry_t         wdata,
  output entry_t         rdata,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  logic [PTR_W:0] wptr;
  logic [PTR_W:0] rptr;
  entry_t         mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset)
      mem[wptr[PTR_W-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[PTR_W-1:0]];
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W-1:0] == rptr[PTR_W-1:0])
              && (wptr[PTR_W] != rptr[PTR_W]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, credit-based imem issue, fetch FIFO.
// Optional counters stat_fetched/stat_squashed under `FETCH_STATS_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_squashed
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CW    = PTR_W + 2;
  localparam logic [ADDR_W-1:0] LOW_MASK =
    ADDR_W'((1 << PC_ALIGN_BITS) - 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [PTR_W:0]    occ;
  logic [CW-1:0]     need;
  entry_t            head;
  entry_t            tail;

  assign pop  = out_valid && out_ready;
  assign push = inflight && !redirect_valid && !reset;

  // Slots already promised: buffered plus in flight, minus what leaves now.
  assign need = CW'(occ) + CW'(inflight) - CW'(pop);

  assign imem_req  = !reset && !redirect_valid
                  && (need < CW'(DEPTH));
  assign imem_addr = reset ? RESET_PC : fetch_pc;

  assign out_valid = !reset && !fifo_empty;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc : '0;

  assign tail.instr = imem_rdata;
  assign tail.pc    = inflight_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= imem_req;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~LOW_MASK;
      end else if (imem_req) begin
        fetch_pc    <= fetch_pc + ADDR_W'(INSTR_BYTES);
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (tail),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

  no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(fifo_full && push && !pop));

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched  <= '0;
      stat_squashed <= '0;
    end else begin
      if (pop)
        stat_fetched <= stat_fetched + 32'd1;
      // A pop in the redirect cycle still completes, so it is not squashed.
      if (redirect_valid)
        stat_squashed <= stat_squashed + 32'(occ)
                       - 32'(pop) + 32'(inflight);
    end
  end
`endif

endmodule
